// File: rtl/compositor_pkg.sv
// Shared constants and pair-index helpers for the layer compositor and its drawers.
package compositor_pkg;

    localparam int MAX_LAYERS = 8;
    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    // Lexicographic index of pair (i,j), i<j, among n layers.
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    function automatic int num_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction

endpackage

// File: rtl/pair_hit_tracker.sv
// Per-pair frame accumulator: one-shot first-overlap event and published frame hit flag.
module pair_hit_tracker (
    input  logic clk,
    input  logic resetN,
    input  logic ov,
    input  logic startOfFrame,
    output logic hitEvent,
    output logic pairHit
);

    logic r_acc;
    logic r_hit;
    logic r_pair;

    // The startOfFrame pixel belongs to the new frame, so it seeds acc rather than ORing into it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_acc  <= 1'b0;
            r_hit  <= 1'b0;
            r_pair <= 1'b0;
        end else if (startOfFrame) begin
            r_pair <= r_acc;
            r_acc  <= ov;
            r_hit  <= ov;
        end else begin
            r_acc  <= r_acc | ov;
            r_hit  <= ov & ~r_acc;
        end
    end

    assign hitEvent = r_hit;
    assign pairHit  = r_pair;

endmodule

// File: rtl/layer_compositor.sv
// Fixed-priority pixel compositor with per-pair overlap tracking across frames.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int NUM_PAIRS  = num_pairs(NUM_LAYERS)
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic [NUM_LAYERS-1:0]      drawReq,
    input  logic [NUM_LAYERS-1:0][7:0] layerRGB,
    input  logic [7:0]                 backgroundRGB,
    input  logic                       startOfFrame,
    output logic [7:0]                 RGBOut,
    output logic [NUM_PAIRS-1:0]       hitEvent,
    output logic [NUM_PAIRS-1:0]       pairHit,
    output logic                       anyHit
);

    logic [NUM_LAYERS-1:0] w_grant;
    logic [7:0]            w_rgb;
    logic [7:0]            r_rgb;
    logic [NUM_PAIRS-1:0]  w_hit;
    logic [NUM_PAIRS-1:0]  w_pair;

    // One-hot grant to the lowest requesting index keeps the mux free of a long chain.
    genvar k;
    generate
        for (k = 0; k < NUM_LAYERS; k++) begin : g_grant
            if (k == 0) begin : g_first
                assign w_grant[k] = drawReq[k];
            end else begin : g_rest
                assign w_grant[k] = drawReq[k] & ~(|drawReq[k-1:0]);
            end
        end
    endgenerate

    always_comb begin
        w_rgb = '0;
        for (int n = 0; n < NUM_LAYERS; n++) begin
            w_rgb = w_rgb | ({8{w_grant[n]}} & layerRGB[n]);
        end
        if (!(|drawReq)) w_rgb = backgroundRGB;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_rgb <= 8'h00;
        else         r_rgb <= w_rgb;
    end

    genvar i, j;
    generate
        for (i = 0; i < NUM_LAYERS; i++) begin : g_row
            for (j = i + 1; j < NUM_LAYERS; j++) begin : g_col
                localparam int P = pair_idx(i, j, NUM_LAYERS);
                pair_hit_tracker u_trk (
                    .clk          (clk),
                    .resetN       (resetN),
                    .ov           (drawReq[i] & drawReq[j]),
                    .startOfFrame (startOfFrame),
                    .hitEvent     (w_hit[P]),
                    .pairHit      (w_pair[P])
                );
            end
        end
    endgenerate

    assign RGBOut   = r_rgb;
    assign hitEvent = w_hit;
    assign pairHit  = w_pair;
    // pairHit is the registered copy of acc, so its OR updates on the same edge.
    assign anyHit   = |w_pair;

endmodule
